// File: rtl/insr_pkg.sv
// Shared fetch/decode definitions: reset PC, instruction size,
// canonical NOP, base opcodes and the fetch FSM state type.
package insr_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned INSN_BYTES   = 4;
  localparam logic [31:0] NOP_INSN     = 32'h0000_0013;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BTYPE = 7'b1100011;
  localparam logic [6:0] OP_JTYPE = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/insr_fetch_buf.sv
// Small synchronous FIFO of fetched {instr, pc} pairs.
// A clear empties it and takes priority over push/pop.
module insr_fetch_buf
  import insr_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            clear_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [31:0]     head_instr_o,
  output logic [XLEN-1:0] head_pc_o,
  output logic [AW:0]     occ_o
);

  logic [31:0]     instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     occ_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= NOP_INSN;
        pc_q[i]    <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push_i) begin
        instr_q[wr_q] <= instr_i;
        pc_q[wr_q]    <= pc_i;
        wr_q          <= wr_q + AW'(1);
      end
      if (pop_i) begin
        rd_q <= rd_q + AW'(1);
      end
      occ_q <= occ_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  assign head_instr_o = instr_q[rd_q];
  assign head_pc_o    = pc_q[rd_q];
  assign occ_o        = occ_q;

endmodule

// File: rtl/insr_fetch.sv
// Instruction fetch stage: one request in flight, small word buffer,
// redirect flushes the buffer and drops any in-flight response.
module insr_fetch
  import insr_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            dec_ready,
  output logic [31:0]     format,
  output logic [XLEN-1:0] format_pc,
  output logic            format_valid
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] rpc_al;
  logic            out_q, out_d;
  logic            drop_q, drop_d;
  fetch_state_e    st_q, st_d;
  logic [AW:0]     occ;
  logic [AW+1:0]   need;
  logic            pop, acc_rv;

  assign rpc_al = redirect_pc & ~XLEN'(3);

  assign acc_rv = imem_rvalid & ~redirect & out_q
                & ~drop_q & (st_q == ST_RUN);

  assign format_valid = (occ != '0);
  assign pop = format_valid & dec_ready & ~redirect;

  // Slots still claimed after this cycle: buffered + in flight - leaving.
  assign need = {1'b0, occ} + (AW+2)'(out_q) - (AW+2)'(pop);

  assign imem_req = ~rst & ~redirect & (st_q == ST_RUN)
                  & (~out_q | acc_rv)
                  & (need < (AW+2)'(DEPTH));
  assign imem_addr = pc_q;

  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    out_d    = out_q;
    drop_d   = drop_q;
    st_d     = st_q;
    if (st_q == ST_FLUSH) begin
      if (redirect) pc_d = rpc_al;
      if (imem_rvalid) begin
        out_d  = 1'b0;
        drop_d = 1'b0;
        st_d   = ST_RUN;
      end
    end else if (redirect) begin
      pc_d = rpc_al;
      if (out_q && !imem_rvalid) begin
        drop_d = 1'b1;
        st_d   = ST_FLUSH;
      end else begin
        out_d = 1'b0;
      end
    end else begin
      if (acc_rv) out_d = 1'b0;
      if (imem_req && imem_gnt) begin
        pc_d     = pc_q + XLEN'(INSN_BYTES);
        req_pc_d = pc_q;
        out_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      out_q    <= 1'b0;
      drop_q   <= 1'b0;
      st_q     <= ST_RUN;
    end else begin
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      st_q     <= st_d;
    end
  end

  insr_fetch_buf #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk_i        (clk),
    .rst_i        (rst),
    .push_i       (acc_rv),
    .pop_i        (pop),
    .clear_i      (redirect),
    .instr_i      (imem_rdata),
    .pc_i         (req_pc_q),
    .head_instr_o (format),
    .head_pc_o    (format_pc),
    .occ_o        (occ)
  );

endmodule

// File: tb/tb_insr_fetch.sv
// Bench for insr_fetch: memory model with programmable latencies and
// an in-order program stream scoreboard for fetch and decode sides.
module tb_insr_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic [31:0] format;
  logic [31:0] format_pc;
  logic        format_valid;

  insr_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .dec_ready    (dec_ready),
    .format       (format),
    .format_pc    (format_pc),
    .format_valid (format_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  int          gnt_dly, rv_dly;
  logic        pend_v;
  logic [31:0] pend_a;
  int          pend_cnt;
  logic        hold;
  logic [31:0] held_a;
  int          wcnt;
  logic [31:0] exp_pc, exp_f;
  int          ngrant, npop;
  logic        s_req, s_fv;
  logic [31:0] s_addr;
  logic [31:0] popq[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A3C_96F1;
  endfunction

  task automatic step(input logic rdy, input logic rd,
                      input logic [31:0] rpc);
    logic rv, g;
    @(negedge clk);
    rv = pend_v && (pend_cnt == 0);
    imem_rvalid = rv;
    imem_rdata  = rv ? word(pend_a) : $urandom;
    dec_ready   = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    imem_gnt    = 1'b0;
    #1;
    s_req  = imem_req;
    s_addr = imem_addr;
    s_fv   = format_valid;
    if (rd) begin
      n_cmp++;
      if (imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL redirect_noreq: req=%b want 0", imem_req);
      end
    end
    if (imem_req === 1'b1) begin
      n_cmp++;
      if (imem_addr[1:0] !== 2'b00 ||
          (hold && imem_addr !== held_a)) begin
        n_fail++;
        $display("FAIL addr_stable: addr=%h want %h", imem_addr, held_a);
      end
    end
    g = (imem_req === 1'b1) && (wcnt >= gnt_dly);
    imem_gnt = g;
    if (g) begin
      n_cmp++;
      if (imem_addr !== exp_f) begin
        n_fail++;
        $display("FAIL fetch_addr: addr=%h want %h", imem_addr, exp_f);
      end
      n_cmp++;
      if (pend_v && !rv) begin
        n_fail++;
        $display("FAIL one_outstanding: grant with %h pending", pend_a);
      end
      exp_f += 32'd4;
    end
    #1;
    if (format_valid === 1'b1 && rdy && !rd) begin
      n_cmp++;
      if (format_pc !== exp_pc || format !== word(exp_pc)) begin
        n_fail++;
        $display("FAIL pop_order: pc=%h insn=%h want pc=%h insn=%h",
                 format_pc, format, exp_pc, word(exp_pc));
      end
      popq.push_back(format_pc);
      exp_pc += 32'd4;
      npop++;
    end
    if (rv) pend_v = 1'b0;
    else if (pend_v) pend_cnt--;
    if (g) begin
      pend_v   = 1'b1;
      pend_a   = imem_addr;
      pend_cnt = rv_dly - 1;
      ngrant++;
    end
    if (imem_req === 1'b1 && !g) begin
      hold   = 1'b1;
      held_a = imem_addr;
      wcnt++;
    end else begin
      hold = 1'b0;
      wcnt = 0;
    end
    if (rd) begin
      exp_pc = rpc & 32'hFFFF_FFFC;
      exp_f  = rpc & 32'hFFFF_FFFC;
      hold   = 1'b0;
      wcnt   = 0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    dec_ready = 1'b1;
    #1;
    n_cmp++;
    if (format_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid: got %b want 0", format_valid);
    end
    n_cmp++;
    if (format !== 32'h0000_0013) begin
      n_fail++;
      $display("FAIL rst_format: got %h want 00000013", format);
    end
    n_cmp++;
    if (format_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_format_pc: got %h want 0", format_pc);
    end
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_req: got %b want 0", imem_req);
    end
    @(negedge clk);
    rst = 1'b0;
    pend_v = 1'b0;
    pend_cnt = 0;
    hold = 1'b0;
    wcnt = 0;
    exp_pc = 32'h0;
    exp_f = 32'h0;
    ngrant = 0;
    npop = 0;
    popq.delete();
  endtask

  task automatic test_stream();
    int first, p0;
    test_reset();
    gnt_dly = 0;
    rv_dly = 1;
    first = -1;
    for (int i = 0; i < 12; i++) begin
      p0 = npop;
      step(1'b1, 1'b0, 32'h0);
      if (npop != p0 && first < 0) first = i;
    end
    n_cmp++;
    if (first != 2) begin
      n_fail++;
      $display("FAIL first_pop_latency: got %0d want 2", first);
    end
    n_cmp++;
    if (npop != 10) begin
      n_fail++;
      $display("FAIL stream_rate: got %0d pops want 10", npop);
    end
  endtask

  task automatic test_backpressure();
    test_reset();
    gnt_dly = 0;
    rv_dly = 1;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (s_req !== 1'b0 || s_fv !== 1'b1) begin
      n_fail++;
      $display("FAIL full_blocks: req=%b valid=%b want 0/1", s_req, s_fv);
    end
    n_cmp++;
    if (ngrant != 2 || pend_v) begin
      n_fail++;
      $display("FAIL buffered_words: grants=%0d want 2", ngrant);
    end
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (popq.size() < 4 || popq[0] !== 32'h0 || popq[1] !== 32'h4) begin
      n_fail++;
      $display("FAIL drain_order: got %0d pops want >=4 from 0", popq.size());
    end
  endtask

  task automatic test_redirect_flush();
    int idx;
    test_reset();
    gnt_dly = 0;
    rv_dly = 1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
    rv_dly = 3;
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (s_fv !== 1'b1 || !pend_v || pend_a !== 32'h8) begin
      n_fail++;
      $display("FAIL flush_setup: valid=%b pend=%h want 1/8", s_fv, pend_a);
    end
    step(1'b0, 1'b1, 32'h0000_0102);
    idx = popq.size();
    step(1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (s_fv !== 1'b0 || s_req !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_state: valid=%b req=%b want 0/0", s_fv, s_req);
    end
    step(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (s_req !== 1'b1 || s_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL flush_refetch: req=%b addr=%h want 1/100", s_req, s_addr);
    end
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (popq.size() <= idx || popq[idx] !== 32'h100) begin
      n_fail++;
      $display("FAIL flush_first_pc: %0d pops want first 100", popq.size() - idx);
    end
  endtask

  task automatic test_redirect_same_cycle();
    int idx;
    test_reset();
    gnt_dly = 0;
    rv_dly = 1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0041);
    n_cmp++;
    if (s_fv !== 1'b1 || !imem_rvalid) begin
      n_fail++;
      $display("FAIL same_cycle_setup: valid=%b want 1", s_fv);
    end
    idx = popq.size();
    step(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (s_req !== 1'b1 || s_addr !== 32'h40 || s_fv !== 1'b0) begin
      n_fail++;
      $display("FAIL no_flush: req=%b addr=%h valid=%b want 1/40/0",
               s_req, s_addr, s_fv);
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (popq.size() <= idx || popq[idx] !== 32'h40) begin
      n_fail++;
      $display("FAIL same_cycle_first_pc: %0d pops want first 40",
               popq.size() - idx);
    end
  endtask

  task automatic test_slow_memory();
    test_reset();
    gnt_dly = 3;
    rv_dly = 4;
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (ngrant < 4 || npop < 3) begin
      n_fail++;
      $display("FAIL slow_progress: grants=%0d pops=%0d want >=4/>=3",
               ngrant, npop);
    end
  endtask

  task automatic test_random();
    int total;
    total = 0;
    for (int ph = 0; ph < 3; ph++) begin
      test_reset();
      gnt_dly = $urandom_range(0, 3);
      rv_dly = $urandom_range(1, 4);
      for (int i = 0; i < 150; i++) begin
        step(1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 19) == 0),
             $urandom);
      end
      total += npop;
    end
    n_cmp++;
    if (total < 30) begin
      n_fail++;
      $display("FAIL random_progress: got %0d pops want >=30", total);
    end
  endtask

  task automatic test_wrap_and_reset();
    int idx;
    test_reset();
    gnt_dly = 0;
    rv_dly = 1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'hFFFF_FFFE);
    idx = popq.size();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (popq.size() < idx + 2 || popq[idx] !== 32'hFFFF_FFFC ||
        popq[idx+1] !== 32'h0) begin
      n_fail++;
      $display("FAIL pc_wrap: %0d pops want FFFFFFFC then 0",
               popq.size() - idx);
    end
    test_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (popq.size() < 2 || popq[0] !== 32'h0 || popq[1] !== 32'h4) begin
      n_fail++;
      $display("FAIL restart_pc: %0d pops want 0 then 4", popq.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    dec_ready = 1'b0;
    gnt_dly = 0;
    rv_dly = 1;
    pend_v = 1'b0;
    pend_a = 32'h0;
    pend_cnt = 0;
    hold = 1'b0;
    held_a = 32'h0;
    wcnt = 0;
    exp_pc = 32'h0;
    exp_f = 32'h0;
    ngrant = 0;
    npop = 0;
    s_req = 1'b0;
    s_fv = 1'b0;
    s_addr = 32'h0;
    repeat (2) @(posedge clk);
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_same_cycle();
    test_slow_memory();
    test_random();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
